// File: rtl/mac1d_pipe.sv
// Pipelined WIN_W-tap multiply-accumulate: product stage, registered pairwise adder tree,
// then a rounding shift and saturation in the output register. Sample-to-result latency is $clog2(WIN_W)+2 edges.
module mac1d_pipe #(
  parameter int WIN_W  = 3,
  parameter int DATA_W = 8,
  parameter int KERN_W = 8,
  parameter int SIGNED = 1,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      kern_ld,
  input  logic [WIN_W*KERN_W-1:0]   kern_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIN_W*DATA_W-1:0]   in_arr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_sat
);

  localparam int PROD_W  = DATA_W + KERN_W;
  localparam int TREE_ST = $clog2(WIN_W);
  localparam int ACC_W   = PROD_W + TREE_ST;
  localparam int RED_W   = ACC_W + 1;
  localparam int CMP_W   = ((RED_W > OUT_W) ? RED_W : OUT_W) + 2;
  localparam int RND_SH  = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [RED_W-1:0]        RND     = (SHIFT > 0) ? (RED_W'(1) << RND_SH) : '0;
  localparam logic signed [CMP_W-1:0] ONE     = CMP_W'(1);
  localparam logic signed [CMP_W-1:0] SAT_MAX = (SIGNED != 0) ? (ONE <<< (OUT_W - 1)) - ONE
                                                              : (ONE <<< OUT_W) - ONE;
  localparam logic signed [CMP_W-1:0] SAT_MIN = (SIGNED != 0) ? -(ONE <<< (OUT_W - 1)) : '0;

  // Number of live operands at tree level l (level 0 = products).
  function automatic int cnt_at(input int l);
    return (WIN_W + (1 << l) - 1) >> l;
  endfunction

  logic                 w_en;
  logic [KERN_W-1:0]    r_kern [WIN_W];
  logic [PROD_W-1:0]    w_a_x  [WIN_W];
  logic [PROD_W-1:0]    w_k_x  [WIN_W];
  logic [PROD_W-1:0]    r_prod [WIN_W];
  logic                 r_p_valid;
  logic [ACC_W-1:0]     w_lvl  [TREE_ST+1][WIN_W];
  logic [TREE_ST:0]     w_lvl_vld;

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_W; i++) r_kern[i] <= '0;
    end else if (kern_ld) begin
      for (int i = 0; i < WIN_W; i++) r_kern[i] <= kern_in[i*KERN_W +: KERN_W];
    end
  end

  for (genvar i = 0; i < WIN_W; i++) begin : g_tap
    assign w_a_x[i] = (SIGNED != 0) ? PROD_W'($signed(in_arr[i*DATA_W +: DATA_W]))
                                    : PROD_W'(in_arr[i*DATA_W +: DATA_W]);
    assign w_k_x[i] = (SIGNED != 0) ? PROD_W'($signed(r_kern[i])) : PROD_W'(r_kern[i]);
    assign w_lvl[0][i] = (SIGNED != 0) ? ACC_W'($signed(r_prod[i])) : ACC_W'(r_prod[i]);
  end
  assign w_lvl_vld[0] = r_p_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_p_valid <= 1'b0;
    else if (w_en) r_p_valid <= in_valid;
  end

  // NOTE: datapath registers carry no reset; only the valid bits qualify them, so leaving
  // them out of the async reset keeps the reset tree small and the flops simpler.
  always_ff @(posedge clk) begin
    if (w_en && in_valid) begin
      for (int i = 0; i < WIN_W; i++) r_prod[i] <= w_a_x[i] * w_k_x[i];
    end
  end

  for (genvar l = 1; l <= TREE_ST; l++) begin : g_lvl
    localparam int N_PREV = cnt_at(l - 1);
    localparam int N      = cnt_at(l);
    logic r_vld;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_vld <= 1'b0;
      else if (w_en) r_vld <= w_lvl_vld[l-1];
    end
    assign w_lvl_vld[l] = r_vld;

    for (genvar j = 0; j < N; j++) begin : g_node
      logic [ACC_W-1:0] r_sum;
      if (2*j + 1 < N_PREV) begin : g_add
        always_ff @(posedge clk) if (w_en) r_sum <= w_lvl[l-1][2*j] + w_lvl[l-1][2*j+1];
      end else begin : g_pass
        always_ff @(posedge clk) if (w_en) r_sum <= w_lvl[l-1][2*j];
      end
      assign w_lvl[l][j] = r_sum;
    end
    for (genvar j = N; j < WIN_W; j++) begin : g_zero
      assign w_lvl[l][j] = '0;
    end
  end

  logic [RED_W-1:0]        w_ext;
  logic [RED_W-1:0]        w_rnd;
  logic [RED_W-1:0]        w_red;
  logic signed [CMP_W-1:0] w_cmp;
  logic                    w_over;
  logic                    w_under;
  logic [OUT_W-1:0]        w_res;

  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    w_ext   = (SIGNED != 0) ? RED_W'($signed(w_lvl[TREE_ST][0])) : RED_W'(w_lvl[TREE_ST][0]);
    w_rnd   = w_ext + RND;
    if (SIGNED != 0) w_red = $signed(w_rnd) >>> SHIFT;
    else             w_red = w_rnd >> SHIFT;
    w_cmp   = (SIGNED != 0) ? CMP_W'($signed(w_red)) : CMP_W'(w_red);
    w_over  = w_cmp > SAT_MAX;
    w_under = w_cmp < SAT_MIN;
    w_res   = w_cmp[OUT_W-1:0];
    if (w_over)       w_res = SAT_MAX[OUT_W-1:0];
    else if (w_under) w_res = SAT_MIN[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (w_en) begin
      out_valid <= w_lvl_vld[TREE_ST];
      if (w_lvl_vld[TREE_ST]) begin
        out_data <= w_res;
        out_sat  <= w_over || w_under;
      end
    end
  end

endmodule

// File: tb/tb_mac1d_pipe.sv
// Directed bench for mac1d_pipe: two instances (SHIFT=0 and SHIFT=2) share stimulus;
// vector table plus backpressure, kernel-swap and mid-stream reset sequences.
module tb_mac1d_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        kern_ld = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [23:0] kern_in = '0;
  logic [23:0] in_arr = '0;
  logic        in_ready0, out_valid0, out_sat0;
  logic        in_ready2, out_valid2, out_sat2;
  logic [15:0] out_data0, out_data2;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int k0, k1, k2;
    int a0, a1, a2;
    int e0, s0;
    int e2, s2;
  } vec_t;

  always #5 clk = ~clk;

  mac1d_pipe #(.WIN_W(3), .DATA_W(8), .KERN_W(8), .SIGNED(1), .SHIFT(0), .OUT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .kern_ld(kern_ld), .kern_in(kern_in),
    .in_valid(in_valid), .in_ready(in_ready0), .in_arr(in_arr),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0)
  );

  mac1d_pipe #(.WIN_W(3), .DATA_W(8), .KERN_W(8), .SIGNED(1), .SHIFT(2), .OUT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .kern_ld(kern_ld), .kern_in(kern_in),
    .in_valid(in_valid), .in_ready(in_ready2), .in_arr(in_arr),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_sat(out_sat2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pack3(input int x0, input int x1, input int x2);
    return {x2[7:0], x1[7:0], x0[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_kern(input int k0, input int k1, input int k2);
    kern_in = pack3(k0, k1, k2);
    kern_ld = 1'b1;
    tick();
    kern_ld = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid0 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[12];
    int   c;
    int   sent;
    int   recv;
    int   held;
    bit   stalled_prev;

    tbl[0]  = '{1, 2, 1, 10, 20, 30, 80, 0, 20, 0};
    tbl[1]  = '{-128, -128, -128, -128, -128, -128, 32767, 1, 12288, 0};
    tbl[2]  = '{127, 127, 127, -128, -128, -128, -32768, 1, -12192, 0};
    tbl[3]  = '{127, 127, 127, 127, 127, 127, 32767, 1, 12097, 0};
    tbl[4]  = '{1, 0, 0, 10, 0, 0, 10, 0, 3, 0};
    tbl[5]  = '{1, 0, 0, -10, 0, 0, -10, 0, -2, 0};
    tbl[6]  = '{1, 0, 0, 6, 0, 0, 6, 0, 2, 0};
    tbl[7]  = '{1, 1, 1, 2, 2, 3, 7, 0, 2, 0};
    tbl[8]  = '{3, -5, 7, 100, -50, -20, 410, 0, 103, 0};
    tbl[9]  = '{-1, -1, -1, 127, 127, 127, -381, 0, -95, 0};
    tbl[10] = '{1, 0, 0, -3, 0, 0, -3, 0, -1, 0};
    tbl[11] = '{0, 0, 1, 0, 0, -2, -2, 0, 0, 0};

    #12;
    check("reset out_valid", int'(out_valid0), 0);
    check("reset out_data", int'(out_data0), 0);
    check("reset out_sat", int'(out_sat0), 0);
    check("reset in_ready", int'(in_ready0), 1);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 12; v++) begin
      load_kern(tbl[v].k0, tbl[v].k1, tbl[v].k2);
      in_arr   = pack3(tbl[v].a0, tbl[v].a1, tbl[v].a2);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_out(c);
      check($sformatf("v%0d latency", v), c, 3);
      check($sformatf("v%0d data", v), int'($signed(out_data0)), tbl[v].e0);
      check($sformatf("v%0d sat", v), int'(out_sat0), tbl[v].s0);
      check($sformatf("v%0d data_sh2", v), int'($signed(out_data2)), tbl[v].e2);
      check($sformatf("v%0d sat_sh2", v), int'(out_sat2), tbl[v].s2);
      tick();
      check($sformatf("v%0d valid drop", v), int'(out_valid0), 0);
    end

    // Backpressure: 8 back-to-back samples, out_ready low for cycles 4..8.
    load_kern(1, 2, 1);
    sent = 0;
    recv = 0;
    held = 0;
    stalled_prev = 1'b0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid  = (sent < 8);
      in_arr    = pack3(sent, sent + 1, sent + 2);
      #1;
      if (out_valid0 && !out_ready) begin
        check("bp in_ready low", int'(in_ready0), 0);
        if (stalled_prev) check("bp data hold", int'(out_data0), held);
        held = int'(out_data0);
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (out_valid0 && out_ready) begin
        check($sformatf("bp result %0d", recv), int'($signed(out_data0)), 4*recv + 4);
        recv++;
      end
      if (in_valid && in_ready0) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp results delivered", recv, 8);
    tick();
    check("bp drained", int'(out_valid0), 0);

    // Kernel swap on the same edge that accepts sample k.
    load_kern(1, 1, 1);
    kern_in  = pack3(2, 2, 2);
    kern_ld  = 1'b1;
    in_arr   = pack3(1, 1, 1);
    in_valid = 1'b1;
    tick();
    kern_ld = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_out(c);
    check("swap sample k", int'($signed(out_data0)), 3);
    tick();
    check("swap k+1 valid", int'(out_valid0), 1);
    check("swap sample k+1", int'($signed(out_data0)), 6);
    tick();

    // Reset with samples in flight.
    load_kern(1, 2, 1);
    in_arr   = pack3(1, 1, 1);
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    tick();
    check("rst pre valid", int'(out_valid0), 1);
    rst_n = 1'b0;
    #1;
    check("rst async valid", int'(out_valid0), 0);
    check("rst async valid sh2", int'(out_valid2), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rst idle %0d", i), int'(out_valid0), 0);
    end
    in_arr   = pack3(10, 20, 30);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(c);
    check("rst new valid", int'(out_valid0), 1);
    check("rst zero kernel", int'($signed(out_data0)), 0);
    check("rst zero sat", int'(out_sat0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mac1d_pipe.md
# mac1d_pipe

Pipelined, parametrised 1D multiply-accumulate. It multiplies a WIN_W-tap window by a latched kernel and sums the products through a registered adder tree. It applies a rounding right shift and a saturating reduction to the output width. Streams one window per clock under valid/ready handshake; this is the per-row dot-product engine the 2D convolution / Gaussian-blur stages instantiate once per kernel row.

## Interface
- WIN_W, 3: number of taps (>=1).
- DATA_W, 8: width of one window element.
- KERN_W, 8: width of one kernel coefficient.
- SIGNED, 1: 1 = both operands and result two's complement; 0 = all unsigned.
- SHIFT, 0: arithmetic right shift (with rounding) applied to the accumulated sum.
- OUT_W, 16: output width after saturation.
- Derived (localparam): PROD_W = DATA_W+KERN_W; ACC_W = PROD_W+$clog2(WIN_W); TREE_ST = $clog2(WIN_W); LAT = TREE_ST+2.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- kern_ld  in  1  load strobe for kernel register.
- kern_in  in  WIN_W*KERN_W  kernel; tap i = kern_in[i*KERN_W +: KERN_W].
- in_valid  in  1  window sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_arr  in  WIN_W*DATA_W  window; element i = in_arr[i*DATA_W +: DATA_W].
- out_valid  out  1  out_data/out_sat valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  OUT_W  reduced result.
- out_sat  out  1  result was clipped by saturation.

## Operation
- Kernel register (WIN_W x KERN_W) loads kern_in on any edge with kern_ld=1, independent of handshake and stall.
- Sample accepted on an edge with in_valid && in_ready. The product stage uses the kernel register value present *before* that edge. A kernel load on the same edge affects only later samples.
- Stage P: WIN_W products, each PROD_W bits, signed or unsigned per SIGNED, registered with a valid bit.
- Tree: TREE_ST registered levels of pairwise adds, pairing (0,1),(2,3),...; an odd leftover operand is registered through unchanged. Each level carries a valid bit. Final sum is ACC_W bits and never overflows.
- Reduction (output stage), computed in ACC_W+1 bits:
  - if SHIFT>0, r = (acc + 2^(SHIFT-1)) >>> SHIFT, giving round-half-up; arithmetic shift if SIGNED, logical otherwise.
  - if SHIFT=0, r = acc.
- Saturation:
  - SIGNED=1: clip r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - SIGNED=0: clip r to [0, 2^OUT_W-1].
  - out_sat=1 exactly when clipping occurred.
- Bubbles (stages with valid=0) flow through and never produce output.
- Results emerge in acceptance order. None are dropped or duplicated.

## Timing
- Throughput: one sample per clock when out_ready=1.
- Latency: for a sample accepted at edge t, out_valid=1 after edge t+LAT-1, provided no stall occurs. Example: WIN_W=3 gives LAT=4, so the result appears after edge t+3. WIN_W=1 gives LAT=2.
- Stall: global enable en = !out_valid || out_ready. All pipeline registers advance only when en=1, and in_ready = en (combinational).
- While out_valid=1 and out_ready=0, out_data, out_sat and all stage contents hold.
- out_valid drops the edge after a handshake only if no valid data is behind it.
- Reset values: all valid bits 0, out_valid 0, out_data 0, out_sat 0, kernel register 0. in_ready is 1 out of reset.
- Reset mid-operation: in-flight samples are discarded asynchronously. After rst_n rises, no output appears until a new sample is accepted. The kernel must be reloaded.
- Simultaneous kern_ld and sample acceptance: the sample uses the old kernel, as stated above. kern_ld during a stall still loads.

## Test plan
- Basic (WIN_W=3, SIGNED=1, SHIFT=0, OUT_W=16): kernel {1,2,1}, arr {10,20,30} (element 0 first) -> out_data=80, out_sat=0, out_valid after edge t+3.
- Signed saturation: kernel and arr all -128 -> sum 49152 -> out_data=32767, out_sat=1. Kernel all 127, arr all -128 -> sum -48768 -> out_data=-32768, out_sat=1.
- Rounding (SHIFT=2): sum 10 -> 3. Sum -10 -> -2. Sum 6 -> 2. All with out_sat=0.
- Backpressure: stream 8 samples back-to-back with out_ready low for 5 cycles mid-stream -> all 8 results delivered in order with correct values. in_ready=0 and out_data stable throughout the stall.
- Kernel swap: kern_ld {1,1,1}→{2,2,2} on the same edge that accepts sample k (arr {1,1,1}) -> sample k result 3, sample k+1 result 6.
- Reset mid-stream: rst_n low with 3 samples in flight -> out_valid=0 immediately. After release, no output until a new sample, and a sample without kernel reload yields 0.
